// File: rtl/iir_pkg.sv
// Shared helpers for the IIR output decimator: width arithmetic and saturation.
package iir_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (longint unsigned w = 1; w < value; w = w << 1) begin
      r++;
    end
    return r;
  endfunction

  // Accumulator width: the sum of DECIM samples of 'bitwidth' bits cannot overflow it.
  function automatic int unsigned acc_width(input int unsigned bitwidth, input int unsigned decim);
    return bitwidth + clog2(decim);
  endfunction

  // Clip a signed value into the range of a 'width'-bit two's-complement number.
  function automatic logic signed [63:0] sat_to(input int unsigned width,
                                                input logic signed [63:0] value);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/iir_sample_fifo.sv
// Synchronous show-ahead FIFO for decimated samples. When empty, rdata holds the last
// popped word (0 after reset). Occupancy is an explicit counter.
module iir_sample_fifo
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   level_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  // Status, accepted operations and show-ahead read data.
  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == (PTR_W + 1)'(DEPTH));
    do_pop  = pop && !empty;
    // A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
    do_push = push && (!full || do_pop);
    rdata   = empty ? last_q : mem_q[rptr_q];
    level   = level_q;
  end

  // Storage array; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers, occupancy and the last-popped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      last_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
        last_q <= mem_q[rptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/iir_out_decimator.sv
// Output stage of the order-2 IIR filter: box-car averages DECIM accepted samples,
// saturates to OUT_W bits and queues results in a show-ahead FIFO.
// Define IIR_DEC_ROUND_EN for round-half-up scaling instead of a truncating shift.
module iir_out_decimator
  import iir_pkg::*;
#(
  parameter int unsigned bitwidth   = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [bitwidth-1:0]     y,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [clog2(FIFO_DEPTH):0]     level,
  output logic                           sat,
  output logic                           ovf
);

  localparam int unsigned SHIFT = clog2(DECIM);
  localparam int unsigned ACC_W = acc_width(bitwidth, DECIM);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum;
  logic [SHIFT-1:0]        phase_q;
  logic                    last;
  logic                    push;
  logic                    clip;
  logic                    full;
  logic                    empty;
  logic                    sat_q;
  logic                    ovf_q;
  logic signed [63:0]      avg_wide;
  logic signed [63:0]      avg_sat;
  logic [OUT_W-1:0]        push_data;
`ifdef IIR_DEC_ROUND_EN
  logic signed [ACC_W:0]   half;
  logic signed [ACC_W:0]   sum_r;
  logic signed [ACC_W:0]   avg;
`else
  logic signed [ACC_W-1:0] avg;
`endif

  // Running sum, block-end detection, scaling and saturation of the block average.
  always_comb begin
    sum  = acc_q + {{SHIFT{y[bitwidth-1]}}, y};
    // DECIM is a power of two, so the final phase is all ones.
    last = &phase_q;
    push = in_valid && last;
`ifdef IIR_DEC_ROUND_EN
    half          = '0;
    half[SHIFT-1] = 1'b1;
    // One extra bit so adding the half-LSB cannot wrap.
    sum_r = {sum[ACC_W-1], sum} + half;
    avg   = sum_r >>> SHIFT;
`else
    avg   = sum >>> SHIFT;
`endif
    avg_wide  = 64'(avg);
    avg_sat   = sat_to(OUT_W, avg_wide);
    clip      = (avg_sat != avg_wide);
    push_data = avg_sat[OUT_W-1:0];
  end

  // Accumulator, phase counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      phase_q <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (in_valid) begin
      phase_q <= phase_q + 1'b1;
      acc_q   <= last ? '0 : sum;
      if (last && clip) begin
        sat_q <= 1'b1;
      end
      // Full implies out_valid, so the only rescue for a full push is a same-edge pop.
      if (last && full && !out_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  iir_sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .wdata (push_data),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Handshake and flag outputs.
  always_comb begin
    out_valid = !empty;
    sat       = sat_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_iir_out_decimator.sv
// Scoreboard bench for iir_out_decimator (DECIM=4, OUT_W=16, FIFO_DEPTH=8).
module tb_iir_out_decimator;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] y;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         level;
  logic               sat;
  logic               ovf;

  int checks = 0;
  int passes = 0;
  int n_out  = 0;
  int start;
  int sb[$];

`ifdef IIR_DEC_ROUND_EN
  localparam int E1 = 3;
  localparam int E2 = -2;
`else
  localparam int E1 = 2;
  localparam int E2 = -3;
`endif

  iir_out_decimator #(
    .bitwidth   (32),
    .OUT_W      (16),
    .DECIM      (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .y         (y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .sat       (sat),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    y        = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    check(name, sb.size(), 0);
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid && ready here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got %0d, expected no output", out_data);
      end else begin
        check("out_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; y = 0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_sat", sat, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_data", out_data, 0);

    // 1: ramp, latency, hold-last when empty
    sb.push_back(E1);
    send(1); send(2); send(3);
    check("t1_not_early", out_valid, 0);
    send(4);
    check("t1_latency", out_valid, 1);
    check("t1_level", level, 1);
    drain("t1_drain");
    check("t1_empty", out_valid, 0);
    check("t1_hold_last", out_data, E1);

    // 2: negative ramp, back-to-back then with gaps
    sb.push_back(E2);
    send(-1); send(-2); send(-3); send(-4);
    drain("t2_drain");
    sb.push_back(E2);
    for (int i = 1; i <= 4; i++) begin
      send(-i);
      tick(); tick();
    end
    drain("t2_gap_drain");

    // 3: saturation both ways
    sb.push_back(32767);
    repeat (4) send(40000);
    drain("t3_pos_drain");
    check("t3_sat_pos", sat, 1);
    do_reset();
    check("t3_sat_cleared", sat, 0);
    sb.push_back(-32768);
    repeat (4) send(-40000);
    drain("t3_neg_drain");
    check("t3_sat_neg", sat, 1);
    check("t3_ovf", ovf, 0);

    // 4: overflow drop with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i % 4 == 3 && i < 32) sb.push_back(5);
      send(5);
    end
    check("t4_level_full", level, 8);
    check("t4_ovf", ovf, 1);
    check("t4_valid", out_valid, 1);
    tick(); tick(); tick();
    check("t4_data_steady", out_data, 5);
    start = n_out;
    out_ready = 1'b1;
    drain("t4_drain");
    tick(); tick(); tick();
    check("t4_count", n_out - start, 8);
    check("t4_level_empty", level, 0);

    // 5: full FIFO with push and pop on the same edge
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 3) sb.push_back(5);
      send(5);
    end
    check("t5_level_full", level, 8);
    sb.push_back(9);
    send(9); send(9); send(9);
    in_valid  = 1'b1;
    y         = 9;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t5_level_stays", level, 8);
    check("t5_ovf_clear", ovf, 0);
    out_ready = 1'b1;
    drain("t5_drain");
    check("t5_level_empty", level, 0);

    // 6: reset mid-block discards the partial sum
    do_reset();
    send(7); send(7);
    do_reset();
    check("t6_level", level, 0);
    start = n_out;
    sb.push_back(1);
    repeat (4) send(1);
    drain("t6_drain");
    tick(); tick(); tick(); tick();
    check("t6_count", n_out - start, 1);
    check("t6_sat", sat, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
